spi_mem_master: RTL and testbench
=================================

Name: spi_mem_master

Overview:
- Shared-bus SPI engine sitting directly downstream of the memory controller; drives the SoC pins flash_cs_n, ram_cs_n, spi_sclk, spi_mosi and samples spi_miso.
- Executes one 03h read or 02h write transaction per request: 24-bit address, then 1, 2 or 4 data bytes.
- Targets the SPI Flash (instruction space) or the SPI RAM (data space).
- The memory controller issues a request, waits for done, and collects rdata.

Parameters:
CLK_DIV, 1, SPI half-period in clk cycles (>=1); SCLK = clk/(2*CLK_DIV)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
start  input  1  request strobe; accepted only in IDLE
sel  input  1  0 = flash (flash_cs_n), 1 = RAM (ram_cs_n)
we  input  1  1 = write (RAM only), 0 = read
addr  input  24  byte address, latched on accept
wdata  input  32  write data, latched on accept
nbytes  input  3  byte count; 1, 2, anything else = 4
rdata  output  32  read data, little-endian, zero-extended
busy  output  1  transaction in progress
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse with done when a request is rejected
flash_cs_n  output  1  flash chip select, active low
ram_cs_n  output  1  RAM chip select, active low
spi_sclk  output  1  SPI clock, mode 0 (idle low)
spi_mosi  output  1  SPI data out, MSB first
spi_miso  input  1  SPI data in

Behaviour:
- Clock and reset: clk; rst_n is synchronous, active-low.
- Reset values: flash_cs_n=1, ram_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, err=0, rdata=0, state=IDLE.
- Reset asserted mid-transaction: the next edge returns to IDLE with CS high and sclk low. No done pulse.
- All outputs are registered.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - start=1 latches sel, we, addr, wdata and n (normalised nbytes).
  - The bit counter loads 32+8n.
  - The selected CS drops and busy rises at that same edge.
  - spi_mosi is driven with command bit 7.
- Rejected request: sel=0 with we=1 (flash write).
  - No CS assertion; go straight to DONE.
  - done=1 and err=1 on the next cycle; rdata unchanged.
- Command bytes: 03h for any read, 02h for RAM write.
- Shift order: command, addr[23:16], addr[15:8], addr[7:0], then data.
  - Data goes byte 0 first: wdata[7:0] or rdata[7:0].
  - Each byte is MSB first.
- SETUP: lasts CLK_DIV cycles with sclk low, then enters SHIFT.
- SHIFT, per bit:
  - sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - spi_miso is sampled on the clk edge that ends the high phase, i.e. the same edge that drives sclk low.
  - spi_mosi updates to the next bit on that same edge.
  - After the final bit's low phase, go to HOLD.
- During the command/address phase of a read, MISO samples are discarded.
- During the data phase of a write, MOSI carries wdata and MISO is ignored.
- HOLD: CS stays low, sclk low, for CLK_DIV cycles. Then CS deasserts and the block enters DONE.
- DONE, for one cycle:
  - done=1; busy=0 (busy falls on the same edge done rises).
  - rdata is updated on reads only; bytes beyond n are 0.
  - Returns to IDLE next.
- start in any state other than IDLE is ignored, with no queuing. This guarantees CS is high for at least 2 cycles between transactions.
- Latency: start-accept edge to done=1 is N = CLK_DIV*(2*(32+8n)+2) cycles.
  - CLK_DIV=1, n=4 gives 130.
  - CLK_DIV=1, n=1 gives 82.
- Only one CS is ever low at a time. The unselected CS stays high throughout.
- Between transactions spi_mosi holds 0.

Test Plan:
- Flash read, CLK_DIV=1: sel=0, we=0, addr=000100h, nbytes=4, MISO model returns EF BE AD DE.
  - flash_cs_n low, ram_cs_n high throughout.
  - MOSI = 03 00 01 00.
  - done at cycle 130; rdata=DEADBEEFh.
- RAM write: sel=1, we=1, addr=00ABCDh, wdata=12345678h, nbytes=2.
  - MOSI = 02 00 AB CD 78 56.
  - 48 sclk rising edges; done at cycle 98; rdata unchanged.
- RAM read 1 byte: MISO data byte A5h -> rdata=000000A5h. Also run nbytes=0 and confirm 4 bytes are transferred.
- Start while busy: second start mid-SHIFT -> ignored, exactly one done, CS high at least 2 cycles before a following request is accepted.
- Flash write rejected: sel=0, we=1 -> no CS/sclk activity; done=1 and err=1 one cycle after start.
- Reset and divider:
  - Drop rst_n at bit 20 -> next cycle CS high, sclk 0, busy 0, no done.
  - With CLK_DIV=4 a 4-byte read completes in 520 cycles, with sclk high and low phases of 4 cycles each.

Source files
------------

// File: rtl/spi_mem_master.sv
// SPI mode-0 master for the shared flash/RAM bus: one 03h read or 02h write
// (24-bit address, 1/2/4 data bytes) per accepted request.
module spi_mem_master #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sel,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  nbytes,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        flash_cs_n,
    output logic        ram_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t            state_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [6:0]        bit_cnt_reg;
    logic [62:0]       tx_reg;
    logic [31:0]       rx_reg;
    logic [2:0]        n_reg;
    logic              we_reg;

    logic [2:0]        n_next;
    logic [31:0]       wdata_stream;
    logic [63:0]       tx_next;
    logic [31:0]       rx_data;

    // Data bytes leave byte 0 first, so reverse byte order into the stream.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wswap
        assign wdata_stream[31-8*gi -: 8] = wdata[8*gi +: 8];
    end

    always_comb begin
        n_next  = (nbytes == 3'd1) ? 3'd1 : (nbytes == 3'd2) ? 3'd2 : 3'd4;
        tx_next = {(we ? 8'h02 : 8'h03), addr, (we ? wdata_stream : 32'h0)};
        // The last 8n received bits hold data byte 0 first; re-pack little-endian.
        case (n_reg)
            3'd1:    rx_data = {24'h0, rx_reg[7:0]};
            3'd2:    rx_data = {16'h0, rx_reg[7:0], rx_reg[15:8]};
            default: rx_data = {rx_reg[7:0], rx_reg[15:8], rx_reg[23:16], rx_reg[31:24]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            n_reg       <= '0;
            we_reg      <= 1'b0;
            rdata       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            flash_cs_n  <= 1'b1;
            ram_cs_n    <= 1'b1;
            spi_sclk    <= 1'b0;
            spi_mosi    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (!sel && we) begin
                            // Flash is read-only: reject without touching the bus.
                            state_reg <= DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                        end else begin
                            n_reg       <= n_next;
                            we_reg      <= we;
                            bit_cnt_reg <= 7'd32 + 7'({n_next, 3'b000});
                            tx_reg      <= tx_next[62:0];
                            spi_mosi    <= tx_next[63];
                            flash_cs_n  <= sel;
                            ram_cs_n    <= !sel;
                            busy        <= 1'b1;
                            div_reg     <= DIV_LAST;
                            state_reg   <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (div_reg == '0) begin
                        spi_sclk  <= 1'b1;
                        div_reg   <= DIV_LAST;
                        state_reg <= SHIFT;
                    end else begin
                        div_reg <= div_reg - DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_reg != '0) begin
                        div_reg <= div_reg - DIV_W'(1);
                    end else begin
                        div_reg <= DIV_LAST;
                        if (spi_sclk) begin
                            // Falling edge: sample MISO and present the next MOSI bit.
                            spi_sclk    <= 1'b0;
                            rx_reg      <= {rx_reg[30:0], spi_miso};
                            tx_reg      <= {tx_reg[61:0], 1'b0};
                            spi_mosi    <= (bit_cnt_reg == 7'd1) ? 1'b0 : tx_reg[62];
                            bit_cnt_reg <= bit_cnt_reg - 7'd1;
                        end else if (bit_cnt_reg == 7'd0) begin
                            state_reg <= HOLD;
                        end else begin
                            spi_sclk <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (div_reg == '0) begin
                        flash_cs_n <= 1'b1;
                        ram_cs_n   <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        if (!we_reg) rdata <= rx_data;
                        state_reg  <= DONE;
                    end else begin
                        div_reg <= div_reg - DIV_W'(1);
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: two instances (CLK_DIV=1 and 4) with behavioural
// SPI slaves, a table of directed requests, corner sequences and random requests.
module tb_spi_mem_master;

    localparam int DIV0 = 1;
    localparam int DIV1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start [2];
    logic        sel, we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [2:0]  nbytes;
    logic [31:0] rdata [2];
    logic        busy [2], done [2], err [2];
    logic        flash_cs_n [2], ram_cs_n [2], spi_sclk [2], spi_mosi [2];
    logic        miso0, miso1;

    logic [31:0] resp_word [2];
    logic [31:0] exp_rd [2];
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        int rises; int fl_low; int ram_low; int both_low; int idle_bad;
        int hi_bad; int gap_bad; int csgap_bad; int dones; logic [63:0] cap;
    } stat_t;

    spi_mem_master #(.CLK_DIV(DIV0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sel(sel), .we(we), .addr(addr),
        .wdata(wdata), .nbytes(nbytes), .rdata(rdata[0]), .busy(busy[0]), .done(done[0]),
        .err(err[0]), .flash_cs_n(flash_cs_n[0]), .ram_cs_n(ram_cs_n[0]),
        .spi_sclk(spi_sclk[0]), .spi_mosi(spi_mosi[0]), .spi_miso(miso0));

    spi_mem_master #(.CLK_DIV(DIV1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sel(sel), .we(we), .addr(addr),
        .wdata(wdata), .nbytes(nbytes), .rdata(rdata[1]), .busy(busy[1]), .done(done[1]),
        .err(err[1]), .flash_cs_n(flash_cs_n[1]), .ram_cs_n(ram_cs_n[1]),
        .spi_sclk(spi_sclk[1]), .spi_mosi(spi_mosi[1]), .spi_miso(miso1));

    // Slave response: bit k of the frame; command/address bits are random junk.
    function automatic logic slave_bit(input int d, input int k);
        if (k < 32 || k >= 64) return 1'($urandom_range(0, 1));
        return resp_word[d][8*((k-32)/8) + 7 - ((k-32)%8)];
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_slv
        localparam int DV = (gi == 0) ? DIV0 : DIV1;
        stat_t st = '0;
        logic  miso_bit = 1'b0;
        logic  cs_low_prev = 1'b0;
        logic  sclk_prev = 1'b0;
        logic  seen_rise = 1'b0;
        int    k = 0;
        int    hi_run = 0;
        int    since_rise = 0;
        int    cs_high_run = 100;
        logic  cs_low;
        assign cs_low = !(flash_cs_n[gi] && ram_cs_n[gi]);

        always @(negedge clk) begin
            if (!flash_cs_n[gi]) st.fl_low <= st.fl_low + 1;
            if (!ram_cs_n[gi]) st.ram_low <= st.ram_low + 1;
            if (!flash_cs_n[gi] && !ram_cs_n[gi]) st.both_low <= st.both_low + 1;
            if (done[gi]) st.dones <= st.dones + 1;
            cs_low_prev <= cs_low;
            sclk_prev   <= spi_sclk[gi];
            if (!cs_low) begin
                if (spi_sclk[gi] || spi_mosi[gi]) st.idle_bad <= st.idle_bad + 1;
                cs_high_run <= cs_high_run + 1;
            end else if (!cs_low_prev) begin
                if (cs_high_run < 2) st.csgap_bad <= st.csgap_bad + 1;
                cs_high_run <= 0;
                k           <= 0;
                hi_run      <= 0;
                since_rise  <= 0;
                seen_rise   <= 1'b0;
                miso_bit    <= slave_bit(gi, 0);
            end else begin
                if (spi_sclk[gi] && !sclk_prev) begin
                    st.rises <= st.rises + 1;
                    st.cap   <= {st.cap[62:0], spi_mosi[gi]};
                    if (seen_rise && since_rise != 2*DV-1) st.gap_bad <= st.gap_bad + 1;
                    seen_rise  <= 1'b1;
                    since_rise <= 0;
                end else begin
                    since_rise <= since_rise + 1;
                end
                if (spi_sclk[gi]) begin
                    hi_run <= hi_run + 1;
                end else if (sclk_prev) begin
                    if (hi_run != DV) st.hi_bad <= st.hi_bad + 1;
                    hi_run   <= 0;
                    k        <= k + 1;
                    miso_bit <= slave_bit(gi, k + 1);
                end
            end
        end
    end

    assign miso0 = g_slv[0].miso_bit;
    assign miso1 = g_slv[1].miso_bit;

    function automatic stat_t stat(input int d);
        return (d == 0) ? g_slv[0].st : g_slv[1].st;
    endfunction

    function automatic int div_of(input int d);
        return (d == 0) ? DIV0 : DIV1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One request end to end; poke>=0 re-pulses start that many cycles into the transfer.
    task automatic run_txn(input int d, input logic s, input logic w, input logic [23:0] a,
                           input logic [31:0] wd, input logic [2:0] nb, input logic [31:0] resp,
                           input int poke, output int lat, output logic [31:0] rd);
        int n, bits, exp_lat, cyc;
        logic rej;
        logic [31:0] mask, e, hdr;
        logic [63:0] win;
        stat_t s0, s1;
        n       = (nb == 3'd1) ? 1 : (nb == 3'd2) ? 2 : 4;
        bits    = 32 + 8*n;
        rej     = !s && w;
        exp_lat = rej ? 0 : div_of(d) * (2*bits + 2);
        mask    = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
        cyc = 0;
        while ((busy[d] || done[d]) && cyc < 1000) begin
            @(posedge clk); #1; cyc++;
        end
        @(negedge clk);
        sel = s; we = w; addr = a; wdata = wd; nbytes = nb; resp_word[d] = resp;
        start[d] = 1'b1;
        s0 = stat(d);
        @(posedge clk); #1;
        start[d] = 1'b0;
        if (!rej) chk("busy_on_accept", busy[d], 1);
        cyc = 0;
        while (!done[d] && cyc < exp_lat + 50) begin
            start[d] = (cyc == poke);
            if (cyc == poke) addr = ~a;
            @(posedge clk); #1; cyc++;
        end
        start[d] = 1'b0;
        lat = cyc;
        rd  = rdata[d];
        if (!rej && !w) exp_rd[d] = resp & mask;
        chk("latency", cyc, exp_lat);
        chk("done_err", err[d], rej);
        chk("done_busy", busy[d], 0);
        chk("rdata", rdata[d], exp_rd[d]);
        chk("cs_high_at_done", flash_cs_n[d] & ram_cs_n[d], 1);
        @(posedge clk); #1;
        chk("done_pulse_end", {done[d], err[d]}, 0);
        @(negedge clk); #1;
        s1 = stat(d);
        chk("done_count", s1.dones - s0.dones, 1);
        chk("sclk_rises", s1.rises - s0.rises, rej ? 0 : bits);
        chk("flash_cs_used", s1.fl_low != s0.fl_low, !s && !rej);
        chk("ram_cs_used", s1.ram_low != s0.ram_low, s && !rej);
        chk("cs_low_cycles", (s1.fl_low - s0.fl_low) + (s1.ram_low - s0.ram_low), exp_lat);
        chk("both_cs_low", s1.both_low - s0.both_low, 0);
        chk("idle_bus_quiet", s1.idle_bad - s0.idle_bad, 0);
        chk("sclk_high_phase", s1.hi_bad - s0.hi_bad, 0);
        chk("sclk_period", s1.gap_bad - s0.gap_bad, 0);
        chk("cs_gap", s1.csgap_bad - s0.csgap_bad, 0);
        if (!rej) begin
            win = (bits == 64) ? s1.cap : (s1.cap & ((64'd1 << bits) - 64'd1));
            hdr = 32'(win >> (8*n));
            chk("mosi_cmd_addr", hdr, {(w ? 8'h02 : 8'h03), a});
            if (w) begin
                e = '0;
                for (int i = 0; i < n; i++) e = {e[23:0], wd[8*i +: 8]};
                chk("mosi_wdata", 32'(win) & mask, e);
            end
        end
        $display("txn dut%0d sel=%0d we=%0d addr=%06h nbytes=%0d lat=%0d rdata=%08h err=%0d",
                 d, s, w, a, nb, cyc, rd, rej);
    endtask

    typedef struct {
        int d; logic s; logic w; logic [23:0] a; logic [31:0] wd; logic [2:0] nb;
        logic [31:0] resp; int lat; logic [31:0] rd;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int lat, cyc;
        logic [31:0] rd;
        stat_t r0, r1;

        tbl[0] = '{0, 1'b0, 1'b0, 24'h000100, 32'h0,        3'd4, 32'hDEADBEEF, 130, 32'hDEADBEEF};
        tbl[1] = '{0, 1'b1, 1'b1, 24'h00ABCD, 32'h12345678, 3'd2, 32'h0,        98,  32'hDEADBEEF};
        tbl[2] = '{0, 1'b1, 1'b0, 24'h000010, 32'h0,        3'd1, 32'h776655A5, 82,  32'h000000A5};
        tbl[3] = '{0, 1'b1, 1'b0, 24'h000020, 32'h0,        3'd0, 32'h11223344, 130, 32'h11223344};
        tbl[4] = '{0, 1'b0, 1'b1, 24'h000030, 32'hFFFFFFFF, 3'd4, 32'h0,        0,   32'h11223344};
        tbl[5] = '{1, 1'b0, 1'b0, 24'h000400, 32'h0,        3'd4, 32'hCAFEF00D, 520, 32'hCAFEF00D};
        tbl[6] = '{0, 1'b1, 1'b0, 24'h000040, 32'h0,        3'd2, 32'hFFFF5A3C, 98,  32'h00005A3C};

        rst_n = 1'b0; start[0] = 1'b0; start[1] = 1'b0;
        sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; nbytes = '0;
        resp_word[0] = '0; resp_word[1] = '0; exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_cs", {flash_cs_n[d], ram_cs_n[d]}, 2'b11);
            chk("reset_spi", {spi_sclk[d], spi_mosi[d]}, 2'b00);
            chk("reset_flags", {busy[d], done[d], err[d]}, 3'b000);
            chk("reset_rdata", rdata[d], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].d, tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].nb, tbl[i].resp,
                    -1, lat, rd);
            chk("tbl_latency", lat, tbl[i].lat);
            chk("tbl_rdata", rd, tbl[i].rd);
        end

        // Start while busy is ignored, then a request right after completion.
        run_txn(0, 1'b1, 1'b0, 24'h123456, 32'h0, 3'd4, 32'h0BADF00D, 20, lat, rd);
        run_txn(0, 1'b0, 1'b0, 24'h000200, 32'h0, 3'd1, 32'h000000C3, -1, lat, rd);

        // Reset around bit 20 of a RAM read.
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = 24'h00F00F; nbytes = 3'd4; resp_word[0] = 32'h55AA55AA;
        start[0] = 1'b1;
        r0 = stat(0);
        @(posedge clk); #1;
        start[0] = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
            r1 = stat(0);
        end while (r1.rises < r0.rises + 20 && cyc < 200);
        chk("rst_reached_bit20", r1.rises - r0.rises, 20);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_cs", {flash_cs_n[0], ram_cs_n[0]}, 2'b11);
        chk("rst_mid_sclk", spi_sclk[0], 0);
        chk("rst_mid_flags", {busy[0], done[0]}, 2'b00);
        chk("rst_mid_rdata", rdata[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        r1 = stat(0);
        chk("rst_mid_no_done", r1.dones - r0.dones, 0);
        $display("txn dut0 reset at bit 20 of read addr=00f00f");

        for (int i = 0; i < 12; i++) begin
            run_txn((i >= 10) ? 1 : 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    24'($urandom), $urandom, 3'($urandom_range(0, 7)), $urandom, -1, lat, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
